// File: rtl/mem_wb_pkg.sv
// Shared opcode constants and destination-decode helpers for the MEM->WB stage.
// Latency: none (package only). Backpressure: n/a.
package mem_wb_pkg;

    localparam logic [3:0] OP_LW    = 4'b0000;
    localparam logic [3:0] OP_SW    = 4'b0001;
    localparam logic [3:0] OP_LI    = 4'b0010;
    localparam logic [3:0] OP_ADDU  = 4'b0011;
    localparam logic [3:0] OP_ADDIU = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_BGE   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;
    localparam logic [3:0] OP_MULI  = 4'b1001;

    // {wen=0, rd=all ones}; callers truncate to REG_AW+1 bits
    function automatic logic [31:0] no_write_code(input int unsigned reg_aw);
        return (32'd1 << reg_aw) - 32'd1;
    endfunction

    function automatic logic writes_reg(input logic [3:0] opcode);
        case (opcode)
            OP_LW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_MULI: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_dest_decode.sv
// Decodes an instruction word into the writeback destination code {wen, rd}.
// Latency: combinational. Backpressure: none.
module wb_dest_decode
    import mem_wb_pkg::*;
#(
    parameter int IR_W   = 32,
    parameter int REG_AW = 5
) (
    input  logic [IR_W-1:0]   ir_i,
    output logic [REG_AW:0]   reg_num_o
);

    localparam logic [REG_AW:0] NO_WRITE = (REG_AW+1)'(no_write_code(REG_AW));

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic              unused_ir_bits;

    assign opcode         = ir_i[IR_W-1 -: 4];
    assign rd             = ir_i[IR_W-5 -: REG_AW];
    assign unused_ir_bits = ^ir_i[IR_W-5-REG_AW:0];

    assign reg_num_o = writes_reg(opcode) ? {1'b1, rd} : NO_WRITE;

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage: DEPTH-entry in-order result buffer with flush; optional forwarding under MEM_WB_FWD_EN.
// Latency 1 cycle push->visible; in_ready_o depends only on registered occupancy, stalls hold the head.
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IR_W   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IR_W-1:0]   ir_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [REG_AW:0]   reg_num_o
`ifdef MEM_WB_FWD_EN
    ,
    input  logic [REG_AW-1:0] fwd_rs_i,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [REG_AW:0]  NO_WRITE = (REG_AW+1)'(no_write_code(REG_AW));
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [REG_AW:0]   rnum_q [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;

    logic            push;
    logic            pop;
    logic [REG_AW:0] in_reg_num;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    wb_dest_decode #(
        .IR_W   (IR_W),
        .REG_AW (REG_AW)
    ) u_dest_decode (
        .ir_i      (ir_i),
        .reg_num_o (in_reg_num)
    );

    assign in_ready_o  = (count_q != FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;

    assign data_o    = out_valid_o ? data_q[rptr_q] : '0;
    assign reg_num_o = out_valid_o ? rnum_q[rptr_q] : NO_WRITE;

    // Flush wins: a same-cycle pop is still consumed downstream, but all state clears.
    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (flush_i) begin
            count_d = '0;
            rptr_d  = '0;
            wptr_d  = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                rnum_q[i] <= NO_WRITE;
            end
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            if (push && !flush_i) begin
                data_q[wptr_q] <= data_i;
                rnum_q[wptr_q] <= in_reg_num;
            end
        end
    end

`ifdef MEM_WB_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match (youngest) is what remains.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = PTR_W'((int'(rptr_q) + i) % DEPTH);
            if ((CNT_W'(i) < count_q) && rnum_q[fwd_idx][REG_AW] &&
                (rnum_q[fwd_idx][REG_AW-1:0] == fwd_rs_i)) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = data_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: directed cases plus randomized traffic against a queue model.
// Forwarding checks are compiled only when MEM_WB_FWD_EN is defined.
module tb_mem_wb_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic [31:0] ir = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic [5:0]  reg_num;
    logic [4:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [5:0]  rn;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    mem_wb_pipe #(
        .DATA_W (32),
        .IR_W   (32),
        .REG_AW (5),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .ir_i        (ir),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out),
        .reg_num_o   (reg_num)
`ifdef MEM_WB_FWD_EN
        ,
        .fwd_rs_i    (fwd_rs),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data)
`endif
    );

`ifndef MEM_WB_FWD_EN
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_rn(input logic [31:0] w);
        logic [3:0] op;
        op = w[31:28];
        if (op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9}) return {1'b1, w[27:23]};
        return 6'b011111;
    endfunction

    // Compare against the queue model, then apply this cycle's handshakes to it.
    always @(negedge clk) begin
        logic        m_valid;
        logic        m_ready;
        logic        m_hit;
        logic [31:0] m_fdata;
        if (!rst_n) mq.delete();
        m_valid = (mq.size() != 0);
        m_ready = (mq.size() != DEPTH);
        chk("m_out_valid", {63'b0, out_valid}, {63'b0, m_valid});
        chk("m_in_ready", {63'b0, in_ready}, {63'b0, m_ready});
        chk("m_data", {32'b0, data_out}, m_valid ? {32'b0, mq[0].d} : 64'd0);
        chk("m_reg_num", {58'b0, reg_num}, m_valid ? {58'b0, mq[0].rn} : 64'h1f);
        m_hit   = 1'b0;
        m_fdata = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!m_hit && mq[i].rn[5] && mq[i].rn[4:0] == fwd_rs) begin
                m_hit   = 1'b1;
                m_fdata = mq[i].d;
            end
        end
`ifdef MEM_WB_FWD_EN
        chk("m_fwd_hit", {63'b0, fwd_hit}, {63'b0, m_hit});
        chk("m_fwd_data", {32'b0, fwd_data}, {32'b0, m_fdata});
`endif
        if (rst_n) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (m_valid && out_ready) void'(mq.pop_front());
                if (in_valid && m_ready) mq.push_back('{d: data_in, rn: exp_rn(ir)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_reg_num", {58'b0, reg_num}, 64'h1f);
        chk("rst_data", {32'b0, data_out}, 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("post_rst_reg_num", {58'b0, reg_num}, 64'h1f);
        chk("post_rst_fwd_hit", {63'b0, fwd_hit}, 64'd0);

        // single ADDU r17
        in_valid = 1'b1; ir = 32'h3880_0000; data_in = 32'hDEAD_BEEF; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("addu_valid", {63'b0, out_valid}, 64'd1);
        chk("addu_reg_num", {58'b0, reg_num}, 64'h31);
        chk("addu_data", {32'b0, data_out}, 64'hDEAD_BEEF);
        cyc();
        chk("addu_drained", {63'b0, out_valid}, 64'd0);

        // SW then J, both no-write
        in_valid = 1'b1; ir = 32'h1000_0000; data_in = 32'h1;
        cyc();
        ir = 32'h8000_0000; data_in = 32'h2;
        chk("sw_reg_num", {58'b0, reg_num}, 64'h1f);
        chk("sw_data", {32'b0, data_out}, 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("j_reg_num", {58'b0, reg_num}, 64'h1f);
        chk("j_data", {32'b0, data_out}, 64'h2);
        cyc();
        chk("sw_j_drained", {63'b0, out_valid}, 64'd0);

        // fill to full with writeback stalled; third push refused
        out_ready = 1'b0;
        in_valid = 1'b1; ir = 32'h3880_0000; data_in = 32'hA;
        cyc();
        data_in = 32'hB;
        chk("fill1_ready", {63'b0, in_ready}, 64'd1);
        cyc();
        data_in = 32'hC;
        chk("full_ready", {63'b0, in_ready}, 64'd0);
        chk("full_head_held", {32'b0, data_out}, 64'hA);
        cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("third_refused_ready", {63'b0, in_ready}, 64'd0);
        chk("drain_first", {32'b0, data_out}, 64'hA);
        cyc();
        chk("drain_second", {32'b0, data_out}, 64'hB);
        chk("ready_after_pop", {63'b0, in_ready}, 64'd1);
        cyc();
        chk("drain_empty", {63'b0, out_valid}, 64'd0);

        // flush with two buffered plus a live input
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 32'hD;
        cyc();
        data_in = 32'hE;
        cyc();
        flush = 1'b1; data_in = 32'hF;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_ready", {63'b0, in_ready}, 64'd1);
        cyc();
        chk("flush_no_late", {63'b0, out_valid}, 64'd0);

`ifdef MEM_WB_FWD_EN
        in_valid = 1'b1; ir = {4'b0010, 5'd5, 23'd0}; data_in = 32'd7;
        cyc();
        ir = {4'b0011, 5'd5, 23'd0}; data_in = 32'd9;
        cyc();
        in_valid = 1'b0; fwd_rs = 5'd5;
        #1;
        chk("fwd_r5_hit", {63'b0, fwd_hit}, 64'd1);
        chk("fwd_r5_data", {32'b0, fwd_data}, 64'd9);
        fwd_rs = 5'd6;
        #1;
        chk("fwd_r6_hit", {63'b0, fwd_hit}, 64'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ir        = $urandom;
            ir[27:23] = 5'($urandom_range(0, 3));
            data_in   = $urandom;
            fwd_rs    = 5'($urandom_range(0, 3));
            cyc();
        end
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
